// File: rtl/trigger_detector.sv
// trigger_detector
// Qualifies the raw envelope comparator output into a registered
// packet-present trigger for the backscatter modulator.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   enable         synchronous enable; low forces IDLE and drops the trigger
//   envelope_in    raw comparator output, asynchronous to clock
//   trigger_signal qualified packet-present, registered
//   timeout_pulse  one-cycle pulse when an over-length excitation is cut off
//   packet_count   completed (non-timeout) packets, wraps 255 -> 0
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no packet; waiting for the first high sample
// ST_QUALIFY | counting consecutive high samples toward MIN_ON
// ST_ACTIVE  | trigger high, envelope present
// ST_GAP     | trigger high, envelope dropped; counting low samples
// ST_LOCKOUT | forced release; waiting for GAP_CYCLES consecutive lows
module trigger_detector #(
  parameter int unsigned MIN_ON     = 40,
  parameter int unsigned GAP_CYCLES = 20,
  parameter int unsigned MAX_ON     = 3000050,
  parameter int unsigned CNT_W      = 22
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       envelope_in,
  output logic       trigger_signal,
  output logic       timeout_pulse,
  output logic [7:0] packet_count
);

  localparam int unsigned RUN_MAX = (MIN_ON > GAP_CYCLES) ? MIN_ON : GAP_CYCLES;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [RUN_W-1:0] MIN_TC  = RUN_W'(MIN_ON - 1);
  localparam logic [RUN_W-1:0] GAP_TC  = RUN_W'(GAP_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  // Terminal count at MAX_ON: the trigger is released after exactly MAX_ON
  // high cycles, since dur_cnt already reads 1 during the first high cycle.
  localparam logic [CNT_W-1:0] DUR_TC  = CNT_W'(MAX_ON);
  localparam logic [CNT_W-1:0] DUR_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUALIFY,
    ST_ACTIVE,
    ST_GAP,
    ST_LOCKOUT
  } state_e;

  state_e           state_q, state_d;
  logic             env_meta_q, env_meta_d;
  logic             env_s_q, env_s_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] dur_cnt_q, dur_cnt_d;
  logic             trig_q, trig_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       pkt_q, pkt_d;
  logic             gap_done;

  always_comb begin
    env_meta_d = envelope_in;
    env_s_d    = env_meta_q;
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    trig_d     = trig_q;
    pulse_d    = 1'b0;
    pkt_d      = pkt_q;
    gap_done   = 1'b0;

    if (!enable) begin
      state_d   = ST_IDLE;
      run_cnt_d = '0;
      dur_cnt_d = '0;
      trig_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (env_s_q) begin
            state_d   = ST_QUALIFY;
            run_cnt_d = RUN_ONE;
          end
        end

        ST_QUALIFY: begin
          if (!env_s_q) begin
            state_d   = ST_IDLE;
            run_cnt_d = '0;
          end else if (run_cnt_q == MIN_TC) begin
            state_d   = ST_ACTIVE;
            run_cnt_d = '0;
            dur_cnt_d = DUR_ONE;
            trig_d    = 1'b1;
          end else begin
            run_cnt_d = run_cnt_q + RUN_ONE;
          end
        end

        ST_ACTIVE, ST_GAP: begin
          // Timeout outranks a gap completing on the same edge.
          if (dur_cnt_q == DUR_TC) begin
            state_d   = ST_LOCKOUT;
            run_cnt_d = '0;
            dur_cnt_d = '0;
            trig_d    = 1'b0;
            pulse_d   = 1'b1;
          end else begin
            if (dur_cnt_q != '1) begin
              dur_cnt_d = dur_cnt_q + DUR_ONE;
            end
            if (state_q == ST_ACTIVE) begin
              if (!env_s_q) begin
                // With a single-sample gap the first low already ends the packet.
                if (GAP_CYCLES == 1) begin
                  gap_done = 1'b1;
                end else begin
                  state_d   = ST_GAP;
                  run_cnt_d = RUN_ONE;
                end
              end
            end else begin
              if (env_s_q) begin
                state_d   = ST_ACTIVE;
                run_cnt_d = '0;
              end else if (run_cnt_q == GAP_TC) begin
                gap_done = 1'b1;
              end else begin
                run_cnt_d = run_cnt_q + RUN_ONE;
              end
            end
            if (gap_done) begin
              state_d   = ST_IDLE;
              run_cnt_d = '0;
              dur_cnt_d = '0;
              trig_d    = 1'b0;
              pkt_d     = pkt_q + 8'd1;
            end
          end
        end

        ST_LOCKOUT: begin
          if (env_s_q) begin
            run_cnt_d = '0;
          end else if (run_cnt_q == GAP_TC) begin
            state_d   = ST_IDLE;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + RUN_ONE;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          run_cnt_d = '0;
          dur_cnt_d = '0;
          trig_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      env_meta_q <= 1'b0;
      env_s_q    <= 1'b0;
      run_cnt_q  <= '0;
      dur_cnt_q  <= '0;
      trig_q     <= 1'b0;
      pulse_q    <= 1'b0;
      pkt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      env_meta_q <= env_meta_d;
      env_s_q    <= env_s_d;
      run_cnt_q  <= run_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      trig_q     <= trig_d;
      pulse_q    <= pulse_d;
      pkt_q      <= pkt_d;
    end
  end

  assign trigger_signal = trig_q;
  assign timeout_pulse  = pulse_q;
  assign packet_count   = pkt_q;

endmodule

// File: tb/tb_trigger_detector.sv
// Testbench for trigger_detector with MIN_ON=4, GAP_CYCLES=3, MAX_ON=20.
// Directed vector table, hand-written reset sequence, packet-count wrap and
// randomized envelope runs, all checked against a run-length reference model.
module tb_trigger_detector;
  localparam int MIN_ON = 4;
  localparam int GAP    = 3;
  localparam int MAX_ON = 20;
  localparam int CNT_W  = 22;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       envelope_in;
  logic       trigger_signal;
  logic       timeout_pulse;
  logic [7:0] packet_count;

  trigger_detector #(
    .MIN_ON    (MIN_ON),
    .GAP_CYCLES(GAP),
    .MAX_ON    (MAX_ON),
    .CNT_W     (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .envelope_in   (envelope_in),
    .trigger_signal(trigger_signal),
    .timeout_pulse (timeout_pulse),
    .packet_count  (packet_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: consecutive-run bookkeeping on the synchronized sample.
  bit m_s1, m_s2;
  bit m_trig, m_lock, m_pulse;
  int m_hi, m_lo, m_on, m_cnt;

  typedef struct {
    bit env;
    bit en;
    int reps;
    bit trig;
    bit pulse;
    int cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0;
    m_trig = 0; m_lock = 0; m_pulse = 0;
    m_hi = 0; m_lo = 0; m_on = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit s;
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = envelope_in;
    m_pulse = 0;
    if (!enable) begin
      m_trig = 0; m_lock = 0; m_hi = 0; m_lo = 0; m_on = 0;
    end else begin
      m_hi = s ? m_hi + 1 : 0;
      m_lo = s ? 0 : m_lo + 1;
      if (m_lock) begin
        if (m_lo >= GAP) m_lock = 0;
      end else if (m_trig) begin
        m_on++;
        if (m_on >= MAX_ON) begin
          m_trig = 0; m_pulse = 1; m_lock = 1; m_lo = 0;
        end else if (m_lo >= GAP) begin
          m_trig = 0;
          m_cnt  = (m_cnt + 1) % 256;
        end
      end else if (m_hi >= MIN_ON) begin
        m_trig = 1;
        m_on   = 0;
      end
    end
  endtask

  task automatic tick(input bit env, input bit en);
    @(negedge clock);
    envelope_in = env;
    enable      = en;
    @(posedge clock);
    model_edge();
    #1;
    check("model_trig", {7'd0, trigger_signal}, {7'd0, m_trig});
    check("model_pulse", {7'd0, timeout_pulse}, {7'd0, m_pulse});
    check("model_count", packet_count, m_cnt[7:0]);
  endtask

  function automatic void add(input bit env, input bit en, input int reps,
                              input bit trig, input bit pulse, input int cnt);
    vec_t v;
    v.env = env; v.en = en; v.reps = reps;
    v.trig = trig; v.pulse = pulse; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    // clean packet: 10 high, then low
    add(1,1,5, 0,0,0); add(1,1,1, 1,0,0); add(1,1,4, 1,0,0);
    add(0,1,4, 1,0,0); add(0,1,1, 0,0,1); add(0,1,3, 0,0,1);
    // glitches of 1, 2, 3 high samples
    add(1,1,1, 0,0,1); add(0,1,5, 0,0,1); add(1,1,2, 0,0,1);
    add(0,1,5, 0,0,1); add(1,1,3, 0,0,1); add(0,1,5, 0,0,1);
    // dropouts of 2 bridged, 3 releases, then a fresh packet
    add(1,1,5, 0,0,1); add(1,1,1, 1,0,1); add(0,1,2, 1,0,1);
    add(1,1,3, 1,0,1); add(0,1,2, 1,0,1); add(1,1,3, 1,0,1);
    add(0,1,3, 1,0,1); add(1,1,1, 1,0,1); add(1,1,1, 0,0,2);
    add(1,1,3, 0,0,2); add(1,1,1, 1,0,2); add(0,1,4, 1,0,2);
    add(0,1,1, 0,0,3); add(0,1,3, 0,0,3);
    // 40-cycle excitation: timeout after 20 high cycles, lockout, requalify
    add(1,1,5, 0,0,3); add(1,1,1, 1,0,3); add(1,1,19, 1,0,3);
    add(1,1,1, 0,1,3); add(1,1,1, 0,0,3); add(1,1,13, 0,0,3);
    add(0,1,2, 0,0,3); add(1,1,8, 0,0,3); add(0,1,3, 0,0,3);
    add(1,1,5, 0,0,3); add(1,1,1, 1,0,3); add(0,1,4, 1,0,3);
    add(0,1,1, 0,0,4); add(0,1,3, 0,0,4);
    // enable drop mid-packet, re-enable with envelope still high
    add(1,1,5, 0,0,4); add(1,1,1, 1,0,4); add(1,0,1, 0,0,4);
    add(1,0,2, 0,0,4); add(1,1,3, 0,0,4); add(1,1,1, 1,0,4);
    add(0,1,4, 1,0,4); add(0,1,1, 0,0,5); add(0,1,3, 0,0,5);

    reset       = 1'b0;
    enable      = 1'b1;
    envelope_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_trig", {7'd0, trigger_signal}, 8'd0);
    check("reset_pulse", {7'd0, timeout_pulse}, 8'd0);
    check("reset_count", packet_count, 8'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) tick(0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) tick(vecs[i].env, vecs[i].en);
      check($sformatf("vec%0d_trig", i), {7'd0, trigger_signal}, {7'd0, vecs[i].trig});
      check($sformatf("vec%0d_pulse", i), {7'd0, timeout_pulse}, {7'd0, vecs[i].pulse});
      check($sformatf("vec%0d_count", i), packet_count, vecs[i].cnt[7:0]);
    end

    // asynchronous reset in the middle of an active packet
    repeat (6) tick(1, 1);
    check("pre_reset_trig", {7'd0, trigger_signal}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_trig", {7'd0, trigger_signal}, 8'd0);
    check("async_reset_pulse", {7'd0, timeout_pulse}, 8'd0);
    check("async_reset_count", packet_count, 8'd0);
    model_reset();
    @(negedge clock);
    envelope_in = 1'b0;
    reset       = 1'b1;
    repeat (4) tick(0, 1);

    // 256 clean packets bring the counter back to zero
    for (int p = 0; p < 256; p++) begin
      repeat (6) tick(1, 1);
      repeat (5) tick(0, 1);
      if (p == 254) check("count_255", packet_count, 8'd255);
    end
    check("wrap_count", packet_count, 8'd0);

    // randomized envelope runs with occasional enable drops
    begin
      bit env_r;
      int len;
      env_r = 0;
      for (int k = 0; k < 300; k++) begin
        env_r = ~env_r;
        len   = (k % 7 == 6) ? $urandom_range(15, 30) : $urandom_range(1, 8);
        for (int j = 0; j < len; j++) tick(env_r, $urandom_range(0, 39) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
